// File: rtl/dekatron_pkg.sv
// Shared types and helpers for the dekatron chain sequencer.
// Contents: digit width, command op-codes, FSM state encoding,
// BCD <-> one-hot-of-ten conversion and one-hot validity check.
package dekatron_pkg;

  localparam int unsigned DIGIT_W = 10;
  localparam int unsigned BCD_W   = 4;

  typedef enum logic [1:0] {
    OP_INC = 2'b00,
    OP_DEC = 2'b01,
    OP_SET = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PULSE_A,
    ST_PULSE_B,
    ST_SETTLE,
    ST_CHECK,
    ST_LOAD,
    ST_DONE
  } state_e;

  // Non-BCD nibbles decode to all zeros; callers flag them separately.
  function automatic logic [DIGIT_W-1:0] bcd_to_onehot10(input logic [BCD_W-1:0] bcd);
    logic [DIGIT_W-1:0] r;
    r = '0;
    if (bcd <= BCD_W'(9)) r = DIGIT_W'(1) << bcd;
    return r;
  endfunction

  // Highest set bit wins; only meaningful when is_onehot10 is true.
  function automatic logic [BCD_W-1:0] onehot10_to_bcd(input logic [DIGIT_W-1:0] oh);
    logic [BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(DIGIT_W); i++) begin
      if (oh[i]) r = BCD_W'(i);
    end
    return r;
  endfunction

  function automatic logic is_onehot10(input logic [DIGIT_W-1:0] oh);
    return $onehot(oh);
  endfunction

endpackage

// File: rtl/dekatron_chain_sequencer_if.sv
// Command channel of the dekatron chain sequencer.
// CmdValid/CmdReady handshake, CmdOp (00 inc, 01 dec, 10 set, 11 clear),
// CmdData BCD load value (nibble i -> digit i).
interface dekatron_chain_sequencer_if #(
  parameter int unsigned DIGITS = 4
) ();

  logic                  CmdValid;
  logic                  CmdReady;
  logic [1:0]            CmdOp;
  logic [4*DIGITS-1:0]   CmdData;

  modport master (
    output CmdValid,
    output CmdOp,
    output CmdData,
    input  CmdReady
  );

  modport slave (
    input  CmdValid,
    input  CmdOp,
    input  CmdData,
    output CmdReady
  );

endinterface

// File: rtl/dekatron_phase_timer.sv
// Loadable down-counter timing each sequencer phase.
// Ports: Clk, Rst (async, active-high), load/load_val start a phase of
// load_val clocks, tc_c is high during the last clock of the phase.
module dekatron_phase_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt;

  // Count sits at zero between phases so tc_c stays quiet.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc_c = (cnt == CNT_W'(1));

endmodule

// File: rtl/dekatron_chain_sequencer.sv
// Dekatron chain sequencer: executes inc/dec/set/clear on a chain of
// DIGITS ten-position glow-transfer counters.
// Ports: Clk, Rst (async, active-high); cmd (slave command channel);
// DigitIn one-hot stage outputs; PulseRight_n/PulseLeft_n active-low
// guide pulses; SetEn/SetData stage load; Busy, Done strobe, Overflow
// (valid with Done), sticky Fault.
module dekatron_chain_sequencer
  import dekatron_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                        Clk,
  input  logic                        Rst,
  dekatron_chain_sequencer_if.slave   cmd,
  input  logic [DIGIT_W*DIGITS-1:0]   DigitIn,
  output logic [DIGITS-1:0]           PulseRight_n,
  output logic [DIGITS-1:0]           PulseLeft_n,
  output logic [DIGITS-1:0]           SetEn,
  output logic [DIGIT_W*DIGITS-1:0]   SetData,
  output logic                        Busy,
  output logic                        Done,
  output logic                        Overflow,
  output logic                        Fault
);

  localparam int unsigned MAX_CYC = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e                      state;
  op_e                         op_q;
  logic [IDX_W-1:0]            idx;
  logic                        bad_q;

  logic                        accept_c;
  logic [DIGIT_W-1:0]          cur_c;
  logic                        cur_valid_c;
  logic [BCD_W-1:0]            cur_val_c;
  logic                        wrap_c;
  logic                        last_c;
  logic [IDX_W-1:0]            idx_nxt_c;
  logic [DIGITS-1:0]           mask0_c;
  logic [DIGITS-1:0]           mask_nxt_c;
  logic [DIGIT_W*DIGITS-1:0]   set_oh_c;
  logic                        set_bad_c;
  logic                        tmr_load_c;
  logic [CNT_W-1:0]            tmr_val_c;
  logic                        tc_c;

  assign accept_c = cmd.CmdValid & cmd.CmdReady;

  // Stage under test and its carry/borrow condition.
  assign cur_c       = DigitIn[DIGIT_W*idx +: DIGIT_W];
  assign cur_valid_c = is_onehot10(cur_c);
  assign cur_val_c   = onehot10_to_bcd(cur_c);
  assign wrap_c      = ((op_q == OP_INC) && (cur_val_c == BCD_W'(0))) ||
                       ((op_q == OP_DEC) && (cur_val_c == BCD_W'(9)));
  assign last_c      = (idx == IDX_W'(DIGITS - 1));
  assign idx_nxt_c   = idx + IDX_W'(1);
  assign mask0_c     = ~DIGITS'(1);
  assign mask_nxt_c  = ~(DIGITS'(1) << idx_nxt_c);

  // Decode the incoming BCD word straight into per-stage one-hot loads.
  always_comb begin
    set_oh_c  = '0;
    set_bad_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (cmd.CmdData[BCD_W*i +: BCD_W] > BCD_W'(9)) set_bad_c = 1'b1;
      set_oh_c[DIGIT_W*i +: DIGIT_W] = bcd_to_onehot10(cmd.CmdData[BCD_W*i +: BCD_W]);
    end
  end

  // Timer is (re)loaded on the same edge the FSM enters a timed phase.
  always_comb begin
    tmr_load_c = 1'b0;
    tmr_val_c  = CNT_W'(PULSE_CYCLES);
    case (state)
      ST_IDLE:    tmr_load_c = accept_c;
      ST_PULSE_A: tmr_load_c = tc_c;
      ST_PULSE_B: begin
        tmr_load_c = tc_c;
        tmr_val_c  = CNT_W'(SETTLE_CYCLES);
      end
      ST_CHECK:   tmr_load_c = cur_valid_c & wrap_c & ~last_c;
      default:    tmr_load_c = 1'b0;
    endcase
  end

  dekatron_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .tc_c     (tc_c)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= ST_IDLE;
      op_q         <= OP_INC;
      idx          <= '0;
      bad_q        <= 1'b0;
      cmd.CmdReady <= 1'b1;
      PulseRight_n <= '1;
      PulseLeft_n  <= '1;
      SetEn        <= '0;
      SetData      <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Overflow     <= 1'b0;
      Fault        <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            op_q         <= op_e'(cmd.CmdOp);
            idx          <= '0;
            Busy         <= 1'b1;
            Overflow     <= 1'b0;
            cmd.CmdReady <= 1'b0;
            case (op_e'(cmd.CmdOp))
              OP_INC: begin
                state        <= ST_PULSE_A;
                PulseRight_n <= mask0_c;
              end
              OP_DEC: begin
                state       <= ST_PULSE_A;
                PulseLeft_n <= mask0_c;
              end
              OP_SET: begin
                state   <= ST_LOAD;
                SetData <= set_oh_c;
                SetEn   <= set_bad_c ? '0 : '1;
                bad_q   <= set_bad_c;
              end
              default: begin
                state   <= ST_LOAD;
                SetData <= {DIGITS{DIGIT_W'(1)}};
                SetEn   <= '1;
                bad_q   <= 1'b0;
              end
            endcase
          end
        end

        // Swapping the two pulse vectors hands the low level from the
        // first guide to the second on one edge, so they never overlap.
        ST_PULSE_A: begin
          if (tc_c) begin
            state        <= ST_PULSE_B;
            PulseRight_n <= PulseLeft_n;
            PulseLeft_n  <= PulseRight_n;
          end
        end

        ST_PULSE_B: begin
          if (tc_c) begin
            state        <= ST_SETTLE;
            PulseRight_n <= '1;
            PulseLeft_n  <= '1;
          end
        end

        ST_SETTLE: begin
          if (tc_c) state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (!cur_valid_c) begin
            state    <= ST_DONE;
            Fault    <= 1'b1;
            Overflow <= 1'b0;
            Done     <= 1'b1;
            Busy     <= 1'b0;
          end else if (wrap_c && !last_c) begin
            state <= ST_PULSE_A;
            idx   <= idx_nxt_c;
            if (op_q == OP_INC) PulseRight_n <= mask_nxt_c;
            else                PulseLeft_n  <= mask_nxt_c;
          end else begin
            state    <= ST_DONE;
            Overflow <= wrap_c;
            Done     <= 1'b1;
            Busy     <= 1'b0;
          end
        end

        ST_LOAD: begin
          if (tc_c) begin
            state   <= ST_DONE;
            SetEn   <= '0;
            SetData <= '0;
            Done    <= 1'b1;
            Busy    <= 1'b0;
            if (bad_q)                 Fault <= 1'b1;
            else if (op_q == OP_CLR)   Fault <= 1'b0;
          end
        end

        ST_DONE: begin
          state        <= ST_IDLE;
          cmd.CmdReady <= 1'b1;
          Overflow     <= 1'b0;
        end

        default: begin
          state        <= ST_IDLE;
          cmd.CmdReady <= 1'b1;
          PulseRight_n <= '1;
          PulseLeft_n  <= '1;
          SetEn        <= '0;
          Busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dekatron_chain_sequencer.sv
// Bench for dekatron_chain_sequencer: behavioural bulb chain, a table of
// directed commands, and hand-written sequences for pulse timing, loads,
// faults and asynchronous reset.
module tb_dekatron_chain_sequencer;
  import dekatron_pkg::*;

  localparam int unsigned D = 4;
  localparam int unsigned P = 2;
  localparam int unsigned S = 1;

  logic              Clk = 1'b0;
  logic              Rst;
  logic [10*D-1:0]   DigitIn;
  logic [D-1:0]      PulseRight_n, PulseLeft_n, SetEn;
  logic [10*D-1:0]   SetData;
  logic              Busy, Done, Overflow, Fault;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  dekatron_chain_sequencer_if #(.DIGITS(D)) cmd_if ();

  dekatron_chain_sequencer #(
    .DIGITS(D), .PULSE_CYCLES(P), .SETTLE_CYCLES(S)
  ) dut (
    .Clk(Clk), .Rst(Rst), .cmd(cmd_if), .DigitIn(DigitIn),
    .PulseRight_n(PulseRight_n), .PulseLeft_n(PulseLeft_n),
    .SetEn(SetEn), .SetData(SetData), .Busy(Busy), .Done(Done),
    .Overflow(Overflow), .Fault(Fault)
  );

  // ---------------- bulb model ----------------
  // Right-then-left moves the glow up one cathode, left-then-right down one.
  int           v[D];
  int           pend[D];          // 0 none, 1 right seen, 2 left seen
  logic [D-1:0] pr_prev = '1, pl_prev = '1;
  logic [15:0]  preset_bcd = '0;
  int           preset_go = 0, seen_go = 0;
  bit           force_en = 1'b0;
  logic [9:0]   force_val = '0;

  always @(negedge Clk) begin
    if (preset_go != seen_go) begin
      seen_go = preset_go;
      for (int i = 0; i < int'(D); i++) v[i] = int'(preset_bcd[4*i +: 4]);
    end
    for (int i = 0; i < int'(D); i++) begin
      if (Rst) pend[i] = 0;
      else begin
        if (SetEn[i])
          for (int b = 0; b < 10; b++) if (SetData[10*i+b]) v[i] = b;
        if (!PulseRight_n[i] && pr_prev[i]) begin
          if (pend[i] == 2) begin v[i] = (v[i] + 9) % 10; pend[i] = 0; end
          else pend[i] = 1;
        end
        if (!PulseLeft_n[i] && pl_prev[i]) begin
          if (pend[i] == 1) begin v[i] = (v[i] + 1) % 10; pend[i] = 0; end
          else pend[i] = 2;
        end
      end
    end
    pr_prev = PulseRight_n;
    pl_prev = PulseLeft_n;
  end

  always_comb begin
    DigitIn = '0;
    for (int i = 0; i < int'(D); i++) DigitIn[10*i +: 10] = 10'(1) << v[i];
    if (force_en) DigitIn[9:0] = force_val;
  end

  function automatic logic [15:0] model_bcd();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < int'(D); i++) r[4*i +: 4] = 4'(v[i]);
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preset(input logic [15:0] bcd);
    preset_bcd = bcd;
    preset_go++;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  int           lat;
  logic         got_ovf, got_flt;
  logic [D-1:0] pr_tr[64], pl_tr[64], se_tr[64];
  logic [10*D-1:0] sd_tr[64];
  logic         busy_tr[64];

  // Issue one command from a negedge; lat = cycle number of Done (accept = 0).
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] data);
    int guard;
    guard = 0;
    for (int c = 0; c < 64; c++) begin
      pr_tr[c] = '1; pl_tr[c] = '1; se_tr[c] = '0; sd_tr[c] = '0; busy_tr[c] = 1'b0;
    end
    cmd_if.CmdValid = 1'b1;
    cmd_if.CmdOp    = op;
    cmd_if.CmdData  = data;
    while (!cmd_if.CmdReady && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    chk("ready before accept", 64'(cmd_if.CmdReady), 64'(1));
    @(negedge Clk);
    cmd_if.CmdValid = 1'b0;
    cmd_if.CmdData  = '1;
    lat = 1;
    while (1) begin
      if (lat < 64) begin
        pr_tr[lat] = PulseRight_n; pl_tr[lat] = PulseLeft_n;
        se_tr[lat] = SetEn; sd_tr[lat] = SetData; busy_tr[lat] = Busy;
      end
      if (Done || lat >= 200) break;
      @(negedge Clk);
      lat++;
    end
    got_ovf = Overflow;
    got_flt = Fault;
    @(negedge Clk);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [15:0] data;
    logic [15:0] init;
    logic [15:0] exp_val;
    int          exp_lat;
    logic        exp_ovf;
    logic        exp_flt;
  } vec_t;

  localparam int NV = 15;
  vec_t vt[NV];

  logic [D-1:0] and_r, and_l;

  initial begin
    vt[0]  = '{"inc 0000",  2'b00, 16'h0000, 16'h0000, 16'h0001,  7, 1'b0, 1'b0};
    vt[1]  = '{"inc 0099",  2'b00, 16'h0000, 16'h0099, 16'h0100, 19, 1'b0, 1'b0};
    vt[2]  = '{"inc 0909",  2'b00, 16'h0000, 16'h0909, 16'h0910, 13, 1'b0, 1'b0};
    vt[3]  = '{"inc 9999",  2'b00, 16'h0000, 16'h9999, 16'h0000, 25, 1'b1, 1'b0};
    vt[4]  = '{"dec 0000",  2'b01, 16'h0000, 16'h0000, 16'h9999, 25, 1'b1, 1'b0};
    vt[5]  = '{"dec 0100",  2'b01, 16'h0000, 16'h0100, 16'h0099, 19, 1'b0, 1'b0};
    vt[6]  = '{"dec 0005",  2'b01, 16'h0000, 16'h0005, 16'h0004,  7, 1'b0, 1'b0};
    vt[7]  = '{"set 1234",  2'b10, 16'h1234, 16'h0000, 16'h1234,  3, 1'b0, 1'b0};
    vt[8]  = '{"set 0000",  2'b10, 16'h0000, 16'h5678, 16'h0000,  3, 1'b0, 1'b0};
    vt[9]  = '{"set 12A4",  2'b10, 16'h12A4, 16'h4321, 16'h4321,  3, 1'b0, 1'b1};
    vt[10] = '{"inc fault", 2'b00, 16'h0000, 16'h4321, 16'h4322,  7, 1'b0, 1'b1};
    vt[11] = '{"clear",     2'b11, 16'h0000, 16'h9876, 16'h0000,  3, 1'b0, 1'b0};
    vt[12] = '{"set 9999",  2'b10, 16'h9999, 16'h0000, 16'h9999,  3, 1'b0, 1'b0};
    vt[13] = '{"set F000",  2'b10, 16'hF000, 16'h9999, 16'h9999,  3, 1'b0, 1'b1};
    vt[14] = '{"clear 2",   2'b11, 16'h0000, 16'h0000, 16'h0000,  3, 1'b0, 1'b0};

    cmd_if.CmdValid = 1'b0;
    cmd_if.CmdOp    = 2'b00;
    cmd_if.CmdData  = '0;
    Rst = 1'b1;
    @(negedge Clk);
    chk("rst pulses", 64'({PulseRight_n, PulseLeft_n}), 64'(8'hFF));
    chk("rst set", 64'({SetEn, SetData}), 64'(0));
    chk("rst flags", 64'({Busy, Done, Overflow, Fault}), 64'(0));
    chk("rst ready", 64'(cmd_if.CmdReady), 64'(1));
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);

    // A: single inc, exact pulse timing and Busy window
    preset(16'h0000);
    run_cmd(2'b00, 16'h0000);
    chk("A lat", 64'(lat), 64'(7));
    chk("A val", 64'(model_bcd()), 64'(16'h0001));
    chk("A ovf", 64'(got_ovf), 64'(0));
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("A right c%0d", c), 64'(pr_tr[c]), 64'((c <= 2) ? 4'b1110 : 4'b1111));
      chk($sformatf("A left c%0d", c), 64'(pl_tr[c]), 64'((c == 3 || c == 4) ? 4'b1110 : 4'b1111));
      chk($sformatf("A busy c%0d", c), 64'(busy_tr[c]), 64'(c <= 6));
    end

    // B: single ripple into digit 1, digits 2/3 untouched
    preset(16'h0009);
    run_cmd(2'b00, 16'h0000);
    chk("B lat", 64'(lat), 64'(13));
    chk("B val", 64'(model_bcd()), 64'(16'h0010));
    chk("B d1 right", 64'(pr_tr[7]), 64'(4'b1101));
    chk("B d1 left", 64'(pl_tr[9]), 64'(4'b1101));
    and_r = '1; and_l = '1;
    for (int c = 1; c <= 13; c++) begin and_r &= pr_tr[c]; and_l &= pl_tr[c]; end
    chk("B upper idle", 64'({and_r[3:2], and_l[3:2]}), 64'(4'b1111));

    // C: full borrow ripple, left guide first on every stage
    preset(16'h0000);
    run_cmd(2'b01, 16'h0000);
    chk("C lat", 64'(lat), 64'(25));
    chk("C ovf", 64'(got_ovf), 64'(1));
    chk("C val", 64'(model_bcd()), 64'(16'h9999));
    chk("C d0 first", 64'({pl_tr[1], pr_tr[1]}), 64'({4'b1110, 4'b1111}));
    chk("C d0 second", 64'({pl_tr[3], pr_tr[3]}), 64'({4'b1111, 4'b1110}));
    chk("C d3 order", 64'({pl_tr[19], pr_tr[21]}), 64'({4'b0111, 4'b0111}));

    // D: set load strobe and one-hot data
    preset(16'h0000);
    run_cmd(2'b10, 16'h1234);
    chk("D lat", 64'(lat), 64'(3));
    chk("D seten", 64'({se_tr[1], se_tr[2], se_tr[3]}), 64'({4'hF, 4'hF, 4'h0}));
    chk("D setdata", 64'(sd_tr[1]), 64'({10'h002, 10'h004, 10'h008, 10'h010}));
    chk("D val", 64'(model_bcd()), 64'(16'h1234));

    // E: illegal nibble faults without loading, then clear recovers
    run_cmd(2'b10, 16'h12A4);
    chk("E lat", 64'(lat), 64'(3));
    chk("E seten", 64'({se_tr[1], se_tr[2], se_tr[3]}), 64'(0));
    chk("E fault", 64'(got_flt), 64'(1));
    run_cmd(2'b11, 16'h5555);
    chk("E clr data", 64'(sd_tr[1]), 64'({4{10'h001}}));
    chk("E clr fault", 64'(got_flt), 64'(0));
    chk("E clr val", 64'(model_bcd()), 64'(16'h0000));

    // F: corrupt stage reading aborts the operation with Fault
    preset(16'h0000);
    force_val = 10'b0000000011;
    force_en  = 1'b1;
    run_cmd(2'b00, 16'h0000);
    force_en  = 1'b0;
    chk("F lat", 64'(lat), 64'(7));
    chk("F fault", 64'(got_flt), 64'(1));
    chk("F ovf", 64'(got_ovf), 64'(0));
    chk("F no pulse", 64'({pr_tr[7], pl_tr[7], pr_tr[6], pl_tr[6]}), 64'(16'hFFFF));

    // G: reset in the middle of PULSE_A releases pulses at once
    preset(16'h0000);
    cmd_if.CmdValid = 1'b1;
    cmd_if.CmdOp    = 2'b00;
    @(negedge Clk);
    cmd_if.CmdValid = 1'b0;
    chk("G pulse low", 64'(PulseRight_n), 64'(4'b1110));
    #2 Rst = 1'b1;
    #1;
    chk("G async release", 64'({PulseRight_n, PulseLeft_n}), 64'(8'hFF));
    chk("G async flags", 64'({Busy, Fault}), 64'(0));
    @(negedge Clk);
    #2 Rst = 1'b0;
    @(negedge Clk);
    chk("G ready after", 64'(cmd_if.CmdReady), 64'(1));

    // Table of directed commands
    for (int k = 0; k < NV; k++) begin
      preset(vt[k].init);
      run_cmd(vt[k].op, vt[k].data);
      chk($sformatf("%s lat", vt[k].name), 64'(lat), 64'(vt[k].exp_lat));
      chk($sformatf("%s ovf", vt[k].name), 64'(got_ovf), 64'(vt[k].exp_ovf));
      chk($sformatf("%s fault", vt[k].name), 64'(got_flt), 64'(vt[k].exp_flt));
      chk($sformatf("%s val", vt[k].name), 64'(model_bcd()), 64'(vt[k].exp_val));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
